// File: rtl/q_frag_pipe.sv
// rtl/q_frag_pipe.sv - multi-lane QZ capture register with a serial config chain
// Optional per-lane output inversion is enabled by `define Q_FRAG_ZINV_EN.
module q_frag_pipe #(
  parameter int LANES = 4,
`ifdef Q_FRAG_ZINV_EN
  localparam int CFG_BITS = 2 * LANES
`else
  localparam int CFG_BITS = LANES
`endif
) (
  input  logic                QCK,
  input  logic                QRT,
  input  logic [LANES-1:0]    CZ,
  input  logic [LANES-1:0]    QDI,
  input  logic                QEN,
  input  logic                QST,
  input  logic                CFG_START,
  input  logic                CFG_VLD,
  input  logic                CFG_SI,
  output logic                CFG_BUSY,
  output logic                CFG_DONE,
  output logic [CFG_BITS-1:0] CFG_Q,
  output logic [LANES-1:0]    QZ
);

  localparam int CW = $clog2(CFG_BITS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  cfg_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [LANES-1:0]    qz_q, qz_d;
  logic [LANES-1:0]    qds;
  logic [LANES-1:0]    zinv;

  assign qds = cfg_q[LANES-1:0];

`ifdef Q_FRAG_ZINV_EN
  assign zinv = cfg_q[CFG_BITS-1:LANES];
`else
  assign zinv = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    CFG_DONE = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (CFG_VLD) begin
          // LSB-first: the first bit received drifts down to bit 0
          shadow_d                = shadow_q >> 1;
          shadow_d[CFG_BITS-1]    = CFG_SI;
          cnt_d                   = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        cfg_d    = shadow_q;
        CFG_DONE = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    qz_d = qz_q;
    if (QST) begin
      qz_d = '1;
    end else if (QEN) begin
      for (int i = 0; i < LANES; i++) begin
        qz_d[i] = (qds[i] ? QDI[i] : CZ[i]) ^ zinv[i];
      end
    end
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      qz_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      qz_q     <= qz_d;
    end
  end

  assign CFG_BUSY = (state_q != ST_IDLE);
  assign CFG_Q    = cfg_q;
  assign QZ       = qz_q;

endmodule

// File: tb/tb_q_frag_pipe.sv
// tb/tb_q_frag_pipe.sv - randomized bench for q_frag_pipe against a transaction-level model
// Honours `define Q_FRAG_ZINV_EN the same way the design does.
module tb_q_frag_pipe;

  localparam int LANES = 4;
`ifdef Q_FRAG_ZINV_EN
  localparam int CB = 2 * LANES;
`else
  localparam int CB = LANES;
`endif

  logic             QCK = 1'b0;
  logic             QRT = 1'b0;
  logic [LANES-1:0] CZ = '0;
  logic [LANES-1:0] QDI = '0;
  logic             QEN = 1'b0;
  logic             QST = 1'b0;
  logic             CFG_START = 1'b0;
  logic             CFG_VLD = 1'b0;
  logic             CFG_SI = 1'b0;
  logic             CFG_BUSY;
  logic             CFG_DONE;
  logic [CB-1:0]    CFG_Q;
  logic [LANES-1:0] QZ;

  int n_checks = 0;
  int n_errors = 0;

  q_frag_pipe #(.LANES(LANES)) dut (
    .QCK(QCK), .QRT(QRT), .CZ(CZ), .QDI(QDI), .QEN(QEN), .QST(QST),
    .CFG_START(CFG_START), .CFG_VLD(CFG_VLD), .CFG_SI(CFG_SI),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_Q(CFG_Q), .QZ(QZ)
  );

  always #5 QCK = ~QCK;

  // Reference: a load is "in progress" while collecting bits, then one
  // commit cycle; the word is built from the received bit list.
  logic [LANES-1:0] m_qz = '0;
  logic [CB-1:0]    m_cfg = '0;
  logic             m_loading = 1'b0;
  logic             m_commit = 1'b0;
  logic             m_bits[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [CB-1:0] word;
    if (QRT) begin
      m_qz = '0; m_cfg = '0; m_loading = 0; m_commit = 0; m_bits.delete();
      return;
    end
    if (QST) m_qz = '1;
    else if (QEN) begin
      for (int i = 0; i < LANES; i++) begin
        logic v;
        v = m_cfg[i] ? QDI[i] : CZ[i];
`ifdef Q_FRAG_ZINV_EN
        v = v ^ m_cfg[LANES + i];
`endif
        m_qz[i] = v;
      end
    end
    if (m_commit) begin
      word = '0;
      for (int k = 0; k < CB; k++) word[k] = m_bits[k];
      m_cfg = word; m_commit = 0; m_bits.delete();
    end else if (m_loading) begin
      if (CFG_VLD) m_bits.push_back(CFG_SI);
      if (m_bits.size() == CB) begin
        m_loading = 0; m_commit = 1;
      end
    end else if (CFG_START) begin
      m_loading = 1; m_bits.delete();
    end
  endtask

  task automatic tick();
    @(posedge QCK);
    model_edge();
    #1;
    check_eq("qz", 32'(QZ), 32'(m_qz));
    check_eq("cfg_q", 32'(CFG_Q), 32'(m_cfg));
    check_eq("busy", 32'(CFG_BUSY), 32'(m_loading | m_commit));
    check_eq("done", 32'(CFG_DONE), 32'(m_commit));
  endtask

  // Sends n bits LSB-first from vec with `gap` idle cycles after each bit;
  // returns with the design sitting in the commit cycle.
  task automatic load(input logic [15:0] vec, input int n, input int gap);
    CFG_START = 1; tick(); CFG_START = 0;
    for (int k = 0; k < n; k++) begin
      CFG_VLD = 1; CFG_SI = vec[k]; tick(); CFG_VLD = 0;
      if (k != n - 1) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic do_reset();
    QRT = 1; tick(); QRT = 0;
  endtask

  initial begin
    logic [15:0] v;
    // Reset dominates set and enable
    QRT = 1; QST = 1; QEN = 1; tick();
    check_eq("rst_qz", 32'(QZ), 32'h0);
    check_eq("rst_cfg", 32'(CFG_Q), 32'h0);
    check_eq("rst_busy", 32'(CFG_BUSY), 32'h0);
    QRT = 0; QST = 0;

    // Capture / hold / set with CFG_Q = 0
    CZ = 4'b1010; QEN = 1; tick();
    check_eq("cap", 32'(QZ), 32'hA);
    QEN = 0; CZ = 4'b0101; tick();
    check_eq("hold", 32'(QZ), 32'hA);
    QST = 1; tick();
    check_eq("set", 32'(QZ), 32'hF);
    QST = 0;

`ifndef Q_FRAG_ZINV_EN
    // Gapless load of 1,0,0,1
    load(16'b1001, 4, 0);
    check_eq("done_pulse", 32'(CFG_DONE), 32'h1);
    tick();
    check_eq("done_drop", 32'(CFG_DONE), 32'h0);
    check_eq("cfg_1001", 32'(CFG_Q), 32'h9);
    QDI = 4'b1111; CZ = 4'b0000; QEN = 1; tick();
    check_eq("qds_sel", 32'(QZ), 32'h9);
    QEN = 0;

    // Same word with 3-cycle VLD gaps
    do_reset();
    load(16'b1001, 4, 3); tick();
    check_eq("cfg_gaps", 32'(CFG_Q), 32'h9);
`else
    // Inversion on lanes 0,1 via ZINV bits
    load(16'b0011_0000, 8, 0);
    check_eq("done_pulse", 32'(CFG_DONE), 32'h1);
    tick();
    check_eq("cfg_30", 32'(CFG_Q), 32'h30);
    CZ = 4'b0000; QEN = 1; tick();
    check_eq("zinv", 32'(QZ), 32'h3);
    QST = 1; tick();
    check_eq("zinv_set", 32'(QZ), 32'hF);
    QST = 0; QEN = 0;
    do_reset();
    load(16'b0011_0000, 8, 3); tick();
    check_eq("cfg_gaps", 32'(CFG_Q), 32'h30);
`endif

    // Abort after two bits: old config cleared, no commit
    CFG_START = 1; tick(); CFG_START = 0;
    CFG_VLD = 1; CFG_SI = 1; tick(); tick(); CFG_VLD = 0;
    QRT = 1; tick(); QRT = 0;
    check_eq("abort_busy", 32'(CFG_BUSY), 32'h0);
    check_eq("abort_cfg", 32'(CFG_Q), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("abort_nodone", 32'(CFG_DONE), 32'h0);
    end

    // VLD in IDLE and START mid-SHIFT are ignored
    CFG_VLD = 1; CFG_SI = 1; tick(); tick(); CFG_VLD = 0;
    check_eq("idle_vld", 32'(CFG_BUSY), 32'h0);
    CFG_START = 1; tick(); CFG_START = 0;
    CFG_VLD = 1; CFG_SI = 0; tick(); CFG_VLD = 0;
    CFG_START = 1; tick(); CFG_START = 0;
    v = 16'h0; v[1] = 1'b1;
    for (int k = 1; k < CB; k++) begin
      CFG_VLD = 1; CFG_SI = v[k]; tick();
    end
    CFG_VLD = 0; tick();
    check_eq("start_ignored", 32'(CFG_Q), 32'h2);

    // Commit-edge capture uses the old word, the next edge the new one
    do_reset();
    QDI = '1; CZ = '0; QEN = 1;
    v = 16'h0; v[LANES-1:0] = '1;
    load(v, CB, 0);
    check_eq("pre_commit_qz", 32'(QZ), 32'h0);
    tick();
    check_eq("commit_edge_qz", 32'(QZ), 32'h0);
    tick();
    check_eq("post_commit_qz", 32'(QZ), 32'hF);

    // Random traffic, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      QRT       = ($urandom_range(0, 299) == 0);
      QST       = ($urandom_range(0, 7) == 0);
      QEN       = $urandom_range(0, 1);
      CZ        = LANES'($urandom);
      QDI       = LANES'($urandom);
      CFG_START = ($urandom_range(0, 5) == 0);
      CFG_VLD   = $urandom_range(0, 1);
      CFG_SI    = $urandom_range(0, 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
